// File: rtl/frank_pkg.sv
// Shared types and constants for the instruction-memory loader.
package frank_pkg;

  localparam int unsigned IMEM_DEPTH_W = 128;
  localparam int unsigned WORD_W       = 32;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_LEN,
    LDR_DATA,
    LDR_WRITE,
    LDR_CSUM,
    LDR_DONE
  } ldr_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
  import frank_pkg::*;

  logic              start;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              write;
  logic [WORD_W-1:0] addr_in;
  logic [WORD_W-1:0] data;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output start, in_valid, in_byte,
    input  in_ready, write, addr_in, data, cpu_hold, done, err
  );

  modport slave (
    input  start, in_valid, in_byte,
    output in_ready, write, addr_in, data, cpu_hold, done, err
  );
endinterface

// File: rtl/word_packer.sv
// Packs pushed bytes little-endian into a 32-bit word; full flags the fourth push.
module word_packer
  import frank_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic [7:0]        in_byte,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [1:0]        lane_q;
  logic [WORD_W-1:0] word_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q <= 2'd0;
      word_q <= '0;
    end else if (clear) begin
      lane_q <= 2'd0;
      word_q <= '0;
    end else if (push) begin
      word_q[{lane_q, 3'b000} +: 8] <= in_byte;
      lane_q                       <= lane_q + 2'd1;
    end
  end

  assign word = word_q;
  assign full = push && (lane_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> instruction memory words, holding the core meanwhile.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import frank_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH_W,
  parameter int unsigned BASE  = 0
) (
  input logic          clk,
  input logic          reset_n,
  imem_loader_if.slave bus
);

  ldr_state_e        state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;
  logic              pk_clear, pk_push, pk_full;
  logic [WORD_W-1:0] pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  word_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (pk_clear),
    .push    (pk_push),
    .in_byte (bus.in_byte),
    .word    (pk_word),
    .full    (pk_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LDR_IDLE;
      n_q     <= 8'd0;
      wcnt_q  <= 8'd0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    wcnt_d       = wcnt_q;
    err_d        = err_q;
    hold_d       = hold_q;
    pk_clear     = 1'b0;
    pk_push      = 1'b0;
    bus.in_ready = 1'b0;
    bus.write    = 1'b0;
    bus.done     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    unique case (state_q)
      LDR_IDLE: begin
        if (bus.start) begin
          state_d  = LDR_LEN;
          hold_d   = 1'b1;
          err_d    = 1'b0;
          wcnt_d   = 8'd0;
          pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d   = 8'd0;
`endif
        end
      end
      LDR_LEN: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          n_d = bus.in_byte;
          if (bus.in_byte == 8'd0) begin
            state_d = LDR_DONE;
            hold_d  = 1'b0;
          end else if (32'(bus.in_byte) > DEPTH) begin
            state_d = LDR_DONE;
            hold_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = LDR_DATA;
          end
        end
      end
      LDR_DATA: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          pk_push = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.in_byte;
`endif
          if (pk_full) state_d = LDR_WRITE;
        end
      end
      LDR_WRITE: begin
        bus.write = 1'b1;
        wcnt_d    = wcnt_q + 8'd1;
        if (wcnt_d == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = LDR_CSUM;
`else
          state_d = LDR_DONE;
          hold_d  = 1'b0;
`endif
        end else begin
          state_d = LDR_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      LDR_CSUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = LDR_DONE;
          // A bad checksum keeps the core held until reset or a new start.
          if (bus.in_byte != csum_q) err_d = 1'b1;
          else hold_d = 1'b0;
        end
      end
`endif
      LDR_DONE: begin
        bus.done = 1'b1;
        state_d  = LDR_IDLE;
      end
      default: state_d = LDR_IDLE;
    endcase
  end

  assign bus.addr_in  = bus.write ? (BASE + 32'(wcnt_q)) : '0;
  assign bus.data     = bus.write ? pk_word : '0;
  assign bus.cpu_hold = hold_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;
  import frank_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader_if bus ();

  imem_loader #(
    .DEPTH (128),
    .BASE  (0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.write) begin
      wr_addr.push_back(bus.addr_in);
      wr_data.push_back(bus.data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", name, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    for (int k = 0; k < 50; k++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    bus.in_valid = 1'b0;
    if (!ok) check("byte_accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400; k++) begin
      if (bus.done) break;
      step();
    end
    check("done_seen", {31'b0, bus.done}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
    check({tag, "_write"},    {31'b0, bus.write},    32'd0);
    check({tag, "_addr"},     bus.addr_in,           32'd0);
    check({tag, "_data"},     bus.data,              32'd0);
    check({tag, "_hold"},     {31'b0, bus.cpu_hold}, 32'd0);
    check({tag, "_done"},     {31'b0, bus.done},     32'd0);
    check({tag, "_err"},      {31'b0, bus.err},      32'd0);
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 5);
  endfunction

  initial begin
    logic [7:0]  cs;
    logic [31:0] exp_word;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'd0;

    // Reset and idle
    #12;
    check_idle_outputs("reset");
    reset_n = 1'b1;
    step();
    step();
    check_idle_outputs("idle");

    // start with no data: core held, nothing written
    pulse_start();
    check("start_hold", {31'b0, bus.cpu_hold}, 32'd1);
    check("start_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    step();
    check("stall_hold", {31'b0, bus.cpu_hold}, 32'd1);
    check("stall_nowrite", wr_addr.size(), 32'd0);

    // N=2 stream
    send_byte(8'd2);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hB7); send_byte(8'h07); send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hA3);
`endif
    wait_done();
    check("n2_done_hold", {31'b0, bus.cpu_hold}, 32'd0);
    check("n2_done_err", {31'b0, bus.err}, 32'd0);
    check("n2_count", wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      check("n2_addr0", wr_addr[0], 32'd0);
      check("n2_data0", wr_data[0], 32'h0000_0013);
      check("n2_addr1", wr_addr[1], 32'd1);
      check("n2_data1", wr_data[1], 32'h0000_07B7);
    end
    step();
    check("n2_done_pulse", {31'b0, bus.done}, 32'd0);
    wr_addr.delete(); wr_data.delete();

    // N=0: done two cycles after start
    pulse_start();
    send_byte(8'd0);
    check("n0_done", {31'b0, bus.done}, 32'd1);
    check("n0_err", {31'b0, bus.err}, 32'd0);
    check("n0_hold", {31'b0, bus.cpu_hold}, 32'd0);
    step();
    check("n0_nowrite", wr_addr.size(), 32'd0);

    // N=200 exceeds DEPTH
    pulse_start();
    send_byte(8'd200);
    check("big_done", {31'b0, bus.done}, 32'd1);
    check("big_err", {31'b0, bus.err}, 32'd1);
    step();
    step();
    check("big_err_sticky", {31'b0, bus.err}, 32'd1);
    check("big_nowrite", wr_addr.size(), 32'd0);

    // N=16 with random gaps and a stray start mid-load
    pulse_start();
    check("n16_err_clr", {31'b0, bus.err}, 32'd0);
    send_byte(8'd16);
    cs = 8'd0;
    for (int i = 0; i < 64; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) step();
      if (i == 21) pulse_start();
      cs = cs ^ pat(i);
      send_byte(pat(i));
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs);
`endif
    wait_done();
    check("n16_err", {31'b0, bus.err}, 32'd0);
    check("n16_count", wr_addr.size(), 32'd16);
    if (wr_addr.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        exp_word = {pat(4*k+3), pat(4*k+2), pat(4*k+1), pat(4*k)};
        check($sformatf("n16_addr%0d", k), wr_addr[k], 32'(k));
        check($sformatf("n16_data%0d", k), wr_data[k], exp_word);
      end
    end
    step();
    wr_addr.delete(); wr_data.delete();

    // Reset after 6 bytes of N=4
    pulse_start();
    send_byte(8'd4);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i));
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check("midrst_count", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("midrst_addr", wr_addr[0], 32'd0);
      check("midrst_data", wr_data[0], 32'h4342_4140);
    end
    #2;
    reset_n = 1'b1;
    step();
    step();
    check_idle_outputs("postrst");
    wr_addr.delete(); wr_data.delete();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum keeps the core held
    pulse_start();
    send_byte(8'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h00);
    wait_done();
    check("csum_err", {31'b0, bus.err}, 32'd1);
    check("csum_hold", {31'b0, bus.cpu_hold}, 32'd1);
    step();
    step();
    check("csum_hold_stays", {31'b0, bus.cpu_hold}, 32'd1);
    check("csum_count", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) check("csum_data", wr_data[0], 32'h4433_2211);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the instruction memory. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words and drives the instruction memory's write port (`write`, `addr_in`, `data`) with word addresses starting at `BASE`. Holds the core (`cpu_hold`) while a load is in progress and releases it after the last word is written.

## Interface
- `DEPTH`, 128: instruction memory depth in words; maximum accepted word count.
- `BASE`, 0: first word address written.
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a load when idle; ignored otherwise.
- `in_valid`  in  1  byte available on `in_byte`.
- `in_byte`  in  8  stream byte.
- `in_ready`  out  1  loader accepts `in_byte` this cycle.
- `write`  out  1  one-cycle write strobe to instruction memory.
- `addr_in`  out  32  word address (not byte address); upper bits zero.
- `data`  out  32  word to write.
- `cpu_hold`  out  1  core held (fetch stalled/reset) while high.
- `done`  out  1  one-cycle pulse at load end (success or error).
- `err`  out  1  sticky error flag; cleared by next accepted `start`.

## Operation
- Byte accepted only when `in_valid && in_ready`.
- Stream format: first byte = word count N; then 4·N data bytes, byte 0 = data[7:0].
- States: IDLE → LEN → DATA ⇄ WRITE → DONE → IDLE.
- IDLE: `in_ready`=0. `start` → LEN, `cpu_hold`=1, `err`=0, word counter = 0.
- LEN: `in_ready`=1. Accept N. N=0 → DONE, no writes. N>DEPTH → `err`=1, DONE, no writes. Else → DATA.
- DATA: `in_ready`=1. Byte-lane counter 0..3 selects the byte slot. Fourth byte accepted → WRITE.
- WRITE: `in_ready`=0. `write`=1, `addr_in`=BASE+word counter, `data`=packed word; word counter increments. If the incremented count equals N → DONE, else → DATA.
- DONE: `done`=1, `cpu_hold`=0, → IDLE.
- Word counter 8 bits; address = BASE + counter, zero-extended to 32 bits; no wrap, since N ≤ DEPTH is guaranteed.
- `start` outside IDLE ignored; a stall (`in_valid`=0) holds the state indefinitely.

## Timing
- Reset values: `in_ready`=0, `write`=0, `addr_in`=0, `data`=0, `cpu_hold`=0, `done`=0, `err`=0, state IDLE, counters 0.
- `cpu_hold` rises the cycle after `start` is sampled and falls in the DONE cycle.
- `write` is asserted exactly one cycle after the 4th byte of a word is accepted; `addr_in`/`data` are valid in that cycle.
- Minimum load time: 1 (LEN) + 5·N (DATA+WRITE) + 1 (DONE) cycles after `start`.
- Reset mid-load: immediate return to reset values; a partially packed word is discarded; already-written words remain in memory.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: after the 4·N data bytes, one extra byte is accepted (state CSUM, `in_ready`=1), holding the XOR of all data bytes. On mismatch `err`=1 and `cpu_hold` stays 1 until reset or the next `start`; on match behaviour is normal. N=0 and N>DEPTH skip CSUM.
- Not defined: no CSUM state and no checksum logic; the transition after the last WRITE goes directly to DONE.

## Structure
- Shared package `frank_pkg`: state enum (`LDR_IDLE`, `LDR_LEN`, `LDR_DATA`, `LDR_WRITE`, `LDR_CSUM`, `LDR_DONE`), `IMEM_DEPTH_W` = 128, `WORD_W` = 32.
- Sub-module `word_packer`: byte-lane counter plus 32-bit shift/pack register with `clear`, `push`, `word`, and `full` ports.

## Test plan
- Reset then idle: all outputs 0; `start` with `in_valid`=0 → `cpu_hold`=1, no `write`.
- Stream N=2, bytes 13 00 00 00 B7 07 00 00 → writes (addr 0, 0x00000013), then (addr 1, 0x000007B7); `done` pulse; `cpu_hold`=0.
- N=0 → `done` two cycles after `start`, no `write`, `err`=0.
- N=200 (> DEPTH) → `err`=1, no `write`, `done` pulse.
- Random `in_valid` gaps over N=16 → 16 writes, correct data and ascending addresses; `start` mid-load ignored.
- `reset_n` low after 6 bytes of N=4 → outputs at reset values; only addr 0 was written; with `IMEM_LOADER_CHECKSUM_EN`, a wrong checksum byte → `err`=1 and `cpu_hold` stays 1.
